// File: rtl/execute_stage_pkg.sv
// Shared constants for the LEGv8 execute stage: datapath width, ALU op encodings,
// the B.cond opcode pattern and the NZCV bit layout.
package execute_stage_pkg;

    localparam int WORD = 64;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_EOR   = 4'b0011,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_LSL   = 4'b1000,
        ALU_LSR   = 4'b1001,
        ALU_NOR   = 4'b1100
    } alu_op_e;

    // opcode[10:3] of every B.cond encoding
    localparam logic [7:0] BCOND_OPC = 8'b01010100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/execute_stage_multiplier.sv
// Shift-add multiplier, one multiplier bit per cycle. busy stays high from the
// start edge until the product register is loaded; done pulses the cycle after.
module seq_multiplier #(
    parameter int WIDTH     = 64,
    parameter int MULT_BITS = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(MULT_BITS + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state, state_nxt;
    logic [WIDTH-1:0] mcand, mplier, acc, addend;
    logic [CW-1:0]    cnt;
    logic             last;

    assign last   = (cnt == CW'(MULT_BITS - 1));
    assign addend = mplier[0] ? mcand : '0;
    assign busy   = (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == BUSY) begin
                acc    <= acc + addend;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                // final partial product folds straight into the result register
                if (last) begin
                    product <= acc + addend;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// LEGv8 execute stage: combinational ALU, branch-target adder and flag outputs,
// NZCV status register, and a stalling sequential multiplier.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int MULT_BITS = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] pc,
    input  logic [WORD-1:0] sign_extended_instr,
    input  logic [WORD-1:0] read_data1,
    input  logic [WORD-1:0] read_data2,
    input  logic [10:0]     opcode,
    input  logic            alu_src,
    input  logic [3:0]      alu_op,
    input  logic            update_sreg,
    input  logic            execute_result_loc,
    input  logic            mult_start,
    output logic [WORD-1:0] branch_alu_result,
    output logic [WORD-1:0] alu_result,
    output logic            zero,
    output logic            negative,
    output logic            carry,
    output logic            overflow,
    output logic            stall,
    output logic            multiplier_done
);
    logic [WORD-1:0] op_a, op_b, alu_out, product;
    logic [WORD:0]   sum;
    logic [5:0]      shamt;
    nzcv_t           cur, sreg, flags;
    logic            unused_opc_bits;

    assign unused_opc_bits   = ^opcode[2:0];
    assign op_a              = read_data1;
    assign op_b              = alu_src ? sign_extended_instr : read_data2;
    assign shamt             = sign_extended_instr[5:0];
    assign branch_alu_result = pc + (sign_extended_instr << 2);

    always_comb begin
        alu_out = '0;
        sum     = '0;
        cur     = '0;
        case (alu_op)
            ALU_AND:   alu_out = op_a & op_b;
            ALU_ORR:   alu_out = op_a | op_b;
            ALU_EOR:   alu_out = op_a ^ op_b;
            ALU_PASSB: alu_out = op_b;
            ALU_LSL:   alu_out = op_a << shamt;
            ALU_LSR:   alu_out = op_a >> shamt;
            ALU_NOR:   alu_out = ~(op_a | op_b);
            ALU_ADD: begin
                sum     = {1'b0, op_a} + {1'b0, op_b};
                alu_out = sum[WORD-1:0];
                cur.c   = sum[WORD];
                cur.v   = (op_a[WORD-1] == op_b[WORD-1]) && (alu_out[WORD-1] != op_a[WORD-1]);
            end
            ALU_SUB: begin
                // A + ~B + 1: carry-out is the inverted borrow
                sum     = {1'b0, op_a} + {1'b0, ~op_b} + (WORD+1)'(1);
                alu_out = sum[WORD-1:0];
                cur.c   = sum[WORD];
                cur.v   = (op_a[WORD-1] != op_b[WORD-1]) && (alu_out[WORD-1] != op_a[WORD-1]);
            end
            default:   alu_out = '0;
        endcase
        cur.n = alu_out[WORD-1];
        cur.z = (alu_out == '0);
    end

    always_ff @(posedge clk) begin
        if (reset)            sreg <= '0;
        else if (update_sreg) sreg <= cur;
    end

    // B.cond evaluates stored flags; everything else (CBZ/CBNZ) sees the live ones
    assign flags    = (opcode[10:3] == BCOND_OPC) ? sreg : cur;
    assign negative = flags[FLAG_N];
    assign zero     = flags[FLAG_Z];
    assign carry    = flags[FLAG_C];
    assign overflow = flags[FLAG_V];

    assign alu_result = execute_result_loc ? product : alu_out;

    seq_multiplier #(
        .WIDTH    (WORD),
        .MULT_BITS(MULT_BITS)
    ) u_mult (
        .clk    (clk),
        .reset  (reset),
        .start  (mult_start),
        .a      (read_data1),
        .b      (read_data2),
        .busy   (stall),
        .done   (multiplier_done),
        .product(product)
    );

endmodule

// File: tb/tb_execute_stage.sv
// Directed + randomized bench for execute_stage against a behavioural model.
module tb_execute_stage;
    localparam int MB = 64;
    localparam logic [10:0] OPC_ADD   = 11'h458;
    localparam logic [10:0] OPC_BCOND = 11'h2A0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc = '0, imm = '0, rd1 = '0, rd2 = '0;
    logic [10:0] opcode = OPC_ADD;
    logic        alu_src = 1'b0;
    logic [3:0]  alu_op = '0;
    logic        update_sreg = 1'b0, execute_result_loc = 1'b0, mult_start = 1'b0;
    logic [63:0] branch_alu_result, alu_result;
    logic        zero, negative, carry, overflow, stall, multiplier_done;

    int          vecs = 0;
    int          errs = 0;
    logic [3:0]  m_sreg = '0;
    logic [63:0] m_prod = '0;

    execute_stage #(.MULT_BITS(MB)) dut (
        .clk(clk), .reset(reset), .pc(pc), .sign_extended_instr(imm),
        .read_data1(rd1), .read_data2(rd2), .opcode(opcode), .alu_src(alu_src),
        .alu_op(alu_op), .update_sreg(update_sreg), .execute_result_loc(execute_result_loc),
        .mult_start(mult_start), .branch_alu_result(branch_alu_result),
        .alu_result(alu_result), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .stall(stall), .multiplier_done(multiplier_done)
    );

    always #5 clk = ~clk;

    // returns {N,Z,C,V,result}
    function automatic logic [67:0] ref_alu(input logic [3:0] op, input logic [63:0] a, b,
                                            input logic [5:0] sh);
        logic [63:0] r;
        logic        c, v;
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a ^ b;
            4'b0111: r = b;
            4'b1000: r = a << sh;
            4'b1001: r = a >> sh;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                r = a + b;
                c = (r < a);
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            4'b0110: begin
                r = a - b;
                c = (a >= b);
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            default: r = '0;
        endcase
        return {r[63], (r == 64'd0), c, v, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        assert (act === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [67:0] cur_ref();
        return ref_alu(alu_op, rd1, alu_src ? imm : rd2, imm[5:0]);
    endfunction

    task automatic check_comb(input string tag);
        logic [67:0] r;
        logic [3:0]  f;
        r = cur_ref();
        f = (opcode[10:3] == 8'b01010100) ? m_sreg : r[67:64];
        chk({tag, ".res"}, alu_result, execute_result_loc ? m_prod : r[63:0]);
        chk({tag, ".nzcv"}, {60'd0, negative, zero, carry, overflow}, {60'd0, f});
        chk({tag, ".br"}, branch_alu_result, pc + imm * 64'd4);
    endtask

    task automatic tick();
        logic [67:0] r;
        r = cur_ref();
        @(posedge clk);
        if (reset) begin
            m_sreg = '0;
            m_prod = '0;
        end else if (update_sreg) begin
            m_sreg = r[67:64];
        end
        #1;
    endtask

    task automatic set_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic src = 1'b0, input logic [63:0] im = '0,
                          input logic upd = 1'b0);
        alu_op = o; rd1 = a; rd2 = b; alu_src = src; imm = im; update_sreg = upd;
        opcode = OPC_ADD; execute_result_loc = 1'b0;
        #1;
    endtask

    task automatic run_mult(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input bit interfere);
        rd1 = a; rd2 = b; mult_start = 1'b1; execute_result_loc = 1'b1; update_sreg = 1'b0;
        tick();
        mult_start = 1'b0;
        for (int i = 0; i < MB; i++) begin
            if (interfere) begin
                mult_start = (i == 5);
                rd1 = {$urandom, $urandom};
                rd2 = {$urandom, $urandom};
            end
            #1;
            chk({tag, ".stall"}, {63'd0, stall}, 64'd1);
            chk({tag, ".done_lo"}, {63'd0, multiplier_done}, 64'd0);
            if (i == 3) check_comb({tag, ".hold"});
            mult_start = 1'b0;
            tick();
        end
        m_prod = a * b;
        chk({tag, ".done"}, {63'd0, multiplier_done}, 64'd1);
        chk({tag, ".stall_off"}, {63'd0, stall}, 64'd0);
        chk({tag, ".prod"}, alu_result, m_prod);
        tick();
        chk({tag, ".done_pulse"}, {63'd0, multiplier_done}, 64'd0);
    endtask

    initial begin
        logic [63:0] spec [6];
        spec = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 64'd3};

        // reset state
        reset = 1'b1; mult_start = 1'b1;
        tick(); tick();
        reset = 1'b0; mult_start = 1'b0; execute_result_loc = 1'b1; opcode = OPC_BCOND;
        #1;
        chk("rst.stall", {63'd0, stall}, 64'd0);
        chk("rst.done", {63'd0, multiplier_done}, 64'd0);
        chk("rst.prod", alu_result, 64'd0);
        chk("rst.sreg", {60'd0, negative, zero, carry, overflow}, 64'd0);

        // ADD and branch target
        set_op(4'b0010, 64'd5, 64'd7);
        pc = 64'h40; imm = 64'd3; #1;
        check_comb("add");
        chk("add.const", alu_result, 64'd12);
        chk("br.const", branch_alu_result, 64'h4C);
        chk("add.flags", {60'd0, negative, zero, carry, overflow}, 64'd0);
        tick();

        // SUB sets flags, then B.cond reads them back
        set_op(4'b0110, 64'd3, 64'd3, 1'b0, 64'd0, 1'b1);
        check_comb("sub_eq");
        tick();
        set_op(4'b0000, 64'd0, 64'hFF);
        opcode = OPC_BCOND; #1;
        check_comb("bcond");
        chk("bcond.const", {60'd0, negative, zero, carry, overflow}, 64'b0110);
        tick();

        // overflow and borrow
        set_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        check_comb("add_ovf");
        chk("add_ovf.flags", {60'd0, negative, zero, carry, overflow}, 64'b1001);
        set_op(4'b0110, 64'd0, 64'd1);
        check_comb("sub_brw");
        chk("sub_brw.res", alu_result, 64'hFFFF_FFFF_FFFF_FFFF);

        // shifts and logic
        set_op(4'b1000, 64'd1, 64'd0, 1'b0, 64'd4);
        chk("lsl", alu_result, 64'd16);
        set_op(4'b1001, 64'h100, 64'd0, 1'b0, 64'd4);
        check_comb("lsr");
        set_op(4'b0001, 64'hF0, 64'h0F);
        chk("orr", alu_result, 64'hFF);
        set_op(4'b1100, 64'hF0, 64'h0F);
        chk("nor", alu_result, ~64'hFF);
        set_op(4'b0111, 64'h5, 64'h9, 1'b1, 64'h1234);
        check_comb("passb_imm");

        // multiplies
        run_mult("mul6x7", 64'd6, 64'd7, 1'b0);
        run_mult("mulneg", -64'sd3, 64'd5, 1'b1);
        chk("mulneg.const", alu_result, 64'hFFFF_FFFF_FFFF_FFF1);

        // reset mid-multiply, with start asserted alongside reset
        set_op(4'b0110, 64'd1, 64'd2, 1'b0, 64'd0, 1'b1);
        tick();
        rd1 = 64'd9; rd2 = 64'd11; mult_start = 1'b1; update_sreg = 1'b0;
        execute_result_loc = 1'b1;
        tick();
        mult_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1; mult_start = 1'b1;
        tick();
        reset = 1'b0; mult_start = 1'b0; opcode = OPC_BCOND; #1;
        chk("abort.stall", {63'd0, stall}, 64'd0);
        chk("abort.done", {63'd0, multiplier_done}, 64'd0);
        chk("abort.prod", alu_result, 64'd0);
        chk("abort.sreg", {60'd0, negative, zero, carry, overflow}, 64'd0);
        tick();
        chk("abort.stall2", {63'd0, stall}, 64'd0);
        run_mult("mul_after", 64'd13, 64'd17, 1'b0);

        // randomized ALU/flag/sreg traffic
        for (int n = 0; n < 80; n++) begin
            alu_op = 4'($urandom_range(0, 15));
            rd1 = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 5)] : {$urandom, $urandom};
            rd2 = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 5)] : {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rd2 = rd1;
            imm = {$urandom, $urandom};
            pc = {$urandom, $urandom};
            alu_src = 1'($urandom);
            update_sreg = 1'($urandom);
            execute_result_loc = ($urandom_range(0, 7) == 0);
            opcode = ($urandom_range(0, 2) == 0) ? OPC_BCOND : 11'($urandom);
            #1;
            check_comb("rand");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
